// File: rtl/rom_download_ctrl_pkg.sv
// Shared types and constants for the Blue Print ROM download sequencer.
// Region numbers are 4 KB slots taken from ioctl_addr[24:12].
package blueprint_rom_pkg;

   typedef enum logic [1:0] {
      StArm,
      StIdle,
      StLoad,
      StCheck
   } state_e;

   localparam int unsigned REG_MAIN1 = 0;
   localparam int unsigned REG_MAIN2 = 1;
   localparam int unsigned REG_MAIN3 = 2;
   localparam int unsigned REG_MAIN4 = 3;
   localparam int unsigned REG_MAIN5 = 4;
   localparam int unsigned REG_TILE0 = 5;
   localparam int unsigned REG_TILE1 = 6;
   localparam int unsigned REG_SPR_R = 7;
   localparam int unsigned REG_SPR_B = 8;
   localparam int unsigned REG_SPR_G = 9;
   localparam int unsigned REG_SND0  = 0;
   localparam int unsigned REG_SND1  = 1;

   localparam int unsigned NUM_MAIN_CS = 10;
   localparam int unsigned NUM_SND_CS  = 2;
   localparam int unsigned NUM_CS      = NUM_MAIN_CS + NUM_SND_CS;
   localparam int unsigned CNT_W       = 17;

   localparam int unsigned MAIN_SIZE_DEF = 'hA000;
   localparam int unsigned SND_SIZE_DEF  = 'h2000;

   // Combined vector: bits [9:0] are index-0 regions, bits [11:10] the sound regions.
   function automatic logic [NUM_CS-1:0] region_onehot(input logic idx, input logic [12:0] region);
      logic [NUM_CS-1:0] oh;
      oh = '0;
      if (!idx) begin
         if (region < 13'(NUM_MAIN_CS)) oh = NUM_CS'(1) << region[3:0];
      end else begin
         if (region < 13'(NUM_SND_CS)) oh = NUM_CS'(1) << (4'(NUM_MAIN_CS) + {3'b000, region[0]});
      end
      return oh;
   endfunction

endpackage

// File: rtl/rom_download_ctrl_if.sv
// ioctl download stream in, ROM write port and status out.
interface rom_download_ctrl_if;

   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;

   logic [24:0] dl_addr;
   logic [7:0]  dl_data;
   logic        dl_wr;
   logic [9:0]  main_cs;
   logic [1:0]  snd_cs;
   logic        rom_ready;
   logic        core_reset_n;
   logic        load_error;

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      input  dl_addr, dl_data, dl_wr, main_cs, snd_cs, rom_ready, core_reset_n, load_error
   );

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      output dl_addr, dl_data, dl_wr, main_cs, snd_cs, rom_ready, core_reset_n, load_error
   );

endinterface

// File: rtl/rom_download_ctrl_decode.sv
// Combinational decode of a download address into one-hot ROM selects.
module rom_region_decode
   import blueprint_rom_pkg::*;
#(
   parameter int unsigned MAIN_SIZE = MAIN_SIZE_DEF,
   parameter int unsigned SND_SIZE  = SND_SIZE_DEF
) (
   input  logic        snd_sel_i,
   input  logic [24:0] addr_i,
   output logic [9:0]  main_cs_o,
   output logic [1:0]  snd_cs_o,
   output logic        in_range_o
);

   logic [NUM_CS-1:0] oh;
   logic [24:0]       limit;

   always_comb begin
      limit      = snd_sel_i ? 25'(SND_SIZE) : 25'(MAIN_SIZE);
      oh         = region_onehot(snd_sel_i, addr_i[24:12]);
      in_range_o = (addr_i < limit) && (oh != '0);
      main_cs_o  = in_range_o ? oh[9:0] : '0;
      snd_cs_o   = in_range_o ? oh[11:10] : '0;
   end

endmodule

// File: rtl/rom_download_ctrl.sv
// Download sequencer: routes ioctl bytes to ROM regions, checks set sizes and
// holds the core in reset until both index sets are loaded correctly.
module rom_download_ctrl
   import blueprint_rom_pkg::*;
#(
   parameter int unsigned MAIN_SIZE = MAIN_SIZE_DEF,
   parameter int unsigned SND_SIZE  = SND_SIZE_DEF,
   parameter int unsigned MAIN_IDX  = 0,
   parameter int unsigned SND_IDX   = 1
) (
   input logic               CLK_DL,
   input logic               RESET_N,
   rom_download_ctrl_if.slave bus_io
);

   state_e                 state_q, state_d;
   logic                   snd_sel_q, snd_sel_d;
   logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]             loaded_q, loaded_d;
   logic [1:0]             err_q, err_d;
   logic                   ovf_q, ovf_d;
   logic                   dl_wr_q, dl_wr_d;
   logic [24:0]            dl_addr_q, dl_addr_d;
   logic [7:0]             dl_data_q, dl_data_d;
   logic [9:0]             main_cs_q, main_cs_d;
   logic [1:0]             snd_cs_q, snd_cs_d;
   logic                   rom_ready_q, rom_ready_d;
   logic                   core_reset_n_q, core_reset_n_d;

   logic                   is_main, is_snd, wr_acc;
   logic [CNT_W-1:0]       size_sel;
   logic [9:0]             dec_main_cs;
   logic [1:0]             dec_snd_cs;
   logic                   dec_in_range;

   rom_region_decode #(
      .MAIN_SIZE (MAIN_SIZE),
      .SND_SIZE  (SND_SIZE)
   ) u_decode (
      .snd_sel_i  (snd_sel_q),
      .addr_i     (bus_io.ioctl_addr),
      .main_cs_o  (dec_main_cs),
      .snd_cs_o   (dec_snd_cs),
      .in_range_o (dec_in_range)
   );

   assign is_main  = (bus_io.ioctl_index == 8'(MAIN_IDX));
   assign is_snd   = (bus_io.ioctl_index == 8'(SND_IDX));
   assign size_sel = snd_sel_q ? CNT_W'(SND_SIZE) : CNT_W'(MAIN_SIZE);

   always_comb begin
      state_d   = state_q;
      snd_sel_d = snd_sel_q;
      cnt_d     = cnt_q;
      loaded_d  = loaded_q;
      err_d     = err_q;
      ovf_d     = ovf_q;
      dl_wr_d   = 1'b0;
      main_cs_d = '0;
      snd_cs_d  = '0;
      dl_addr_d = dl_addr_q;
      dl_data_d = dl_data_q;
      wr_acc    = 1'b0;

      unique case (state_q)
         StArm: begin
            if (!bus_io.ioctl_download) state_d = StIdle;
         end
         StIdle: begin
            if (bus_io.ioctl_download && (is_main || is_snd)) begin
               snd_sel_d          = is_snd;
               cnt_d[is_snd]      = '0;
               loaded_d[is_snd]   = 1'b0;
               ovf_d              = 1'b0;
               state_d            = StLoad;
            end
         end
         StLoad: begin
            // A byte arriving with the falling download still belongs to this load.
            wr_acc = bus_io.ioctl_wr;
            if (!bus_io.ioctl_download) state_d = StCheck;
         end
         StCheck: begin
            if ((cnt_q[snd_sel_q] == size_sel) && !ovf_q) begin
               loaded_d[snd_sel_q] = 1'b1;
               err_d[snd_sel_q]    = 1'b0;
            end else begin
               err_d[snd_sel_q]    = 1'b1;
            end
            state_d = StIdle;
         end
         default: state_d = StArm;
      endcase

      if (wr_acc) begin
         if (cnt_q[snd_sel_q] != '1) cnt_d[snd_sel_q] = cnt_q[snd_sel_q] + CNT_W'(1);
         if (dec_in_range) begin
            dl_wr_d   = 1'b1;
            main_cs_d = dec_main_cs;
            snd_cs_d  = dec_snd_cs;
            dl_addr_d = bus_io.ioctl_addr;
            dl_data_d = bus_io.ioctl_dout;
         end else begin
            ovf_d = 1'b1;
         end
      end

      rom_ready_d    = &loaded_d;
      core_reset_n_d = rom_ready_d & ~bus_io.ioctl_download;
   end

   always_ff @(posedge CLK_DL) begin
      if (!RESET_N) begin
         state_q        <= StArm;
         snd_sel_q      <= 1'b0;
         cnt_q          <= '0;
         loaded_q       <= '0;
         err_q          <= '0;
         ovf_q          <= 1'b0;
         dl_wr_q        <= 1'b0;
         dl_addr_q      <= '0;
         dl_data_q      <= '0;
         main_cs_q      <= '0;
         snd_cs_q       <= '0;
         rom_ready_q    <= 1'b0;
         core_reset_n_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         snd_sel_q      <= snd_sel_d;
         cnt_q          <= cnt_d;
         loaded_q       <= loaded_d;
         err_q          <= err_d;
         ovf_q          <= ovf_d;
         dl_wr_q        <= dl_wr_d;
         dl_addr_q      <= dl_addr_d;
         dl_data_q      <= dl_data_d;
         main_cs_q      <= main_cs_d;
         snd_cs_q       <= snd_cs_d;
         rom_ready_q    <= rom_ready_d;
         core_reset_n_q <= core_reset_n_d;
      end
   end

   assign bus_io.dl_wr        = dl_wr_q;
   assign bus_io.dl_addr      = dl_addr_q;
   assign bus_io.dl_data      = dl_data_q;
   assign bus_io.main_cs      = main_cs_q;
   assign bus_io.snd_cs       = snd_cs_q;
   assign bus_io.rom_ready    = rom_ready_q;
   assign bus_io.core_reset_n = core_reset_n_q;
   assign bus_io.load_error   = |err_q;

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Directed bench for rom_download_ctrl: a per-cycle scoreboard checks the ROM
// write port, immediate assertions check the status outputs at key cycles.
module tb_rom_download_ctrl;

   typedef struct packed {
      logic        wr;
      logic [24:0] addr;
      logic [7:0]  data;
      logic [9:0]  main_cs;
      logic [1:0]  snd_cs;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t sb[$];
   int   n_checks;
   int   n_fail;
   logic exp_load;
   logic exp_snd;

   rom_download_ctrl_if bus ();

   rom_download_ctrl dut (
      .CLK_DL  (clk),
      .RESET_N (rst_n),
      .bus_io  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no end of test, expected finish before time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic got, input logic exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
      end
   endtask

   // Compare last cycle's registered output, then drive this cycle and queue its expectation.
   task automatic step(input logic rst, input logic dl, input logic [7:0] idx, input logic wr,
                       input logic [24:0] a, input logic [7:0] d);
      exp_t        e;
      logic [24:0] lim;
      @(negedge clk);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         n_checks++;
         assert (bus.dl_wr === e.wr && bus.main_cs === e.main_cs && bus.snd_cs === e.snd_cs &&
                 (!e.wr || (bus.dl_addr === e.addr && bus.dl_data === e.data))) else begin
            n_fail++;
            $error("FAIL dl_port: observed wr=%0b addr=%h data=%h main=%b snd=%b expected wr=%0b addr=%h data=%h main=%b snd=%b",
                   bus.dl_wr, bus.dl_addr, bus.dl_data, bus.main_cs, bus.snd_cs,
                   e.wr, e.addr, e.data, e.main_cs, e.snd_cs);
         end
      end
      rst_n              = rst;
      bus.ioctl_download = dl;
      bus.ioctl_index    = idx;
      bus.ioctl_wr       = wr;
      bus.ioctl_addr     = a;
      bus.ioctl_dout     = d;
      e   = '0;
      lim = exp_snd ? 25'h2000 : 25'hA000;
      if (rst && exp_load && wr && (a < lim)) begin
         e.wr   = 1'b1;
         e.addr = a;
         e.data = d;
         if (exp_snd) e.snd_cs = 2'b01 << a[12];
         else         e.main_cs = 10'b1 << a[15:12];
      end
      sb.push_back(e);
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 8'h00, 1'b0, 25'h0, 8'h00);
   endtask

   task automatic dl_start(input logic [7:0] idx);
      step(1'b1, 1'b1, idx, 1'b0, 25'h0, 8'h00);
      exp_load = (idx == 8'h00) || (idx == 8'h01);
      exp_snd  = (idx == 8'h01);
   endtask

   task automatic dl_body(input logic [7:0] idx, input int unsigned first, input int unsigned n,
                          input logic fall_on_last, input logic ovf_last);
      logic [24:0] a;
      logic        last;
      for (int unsigned i = first; i < n; i++) begin
         last = (i == n - 1);
         a    = (last && ovf_last) ? ((idx == 8'h01) ? 25'h2000 : 25'hA000) : 25'(i);
         step(1'b1, !(last && fall_on_last), idx, 1'b1, a, 8'($urandom));
      end
      if (!fall_on_last) step(1'b1, 1'b0, idx, 1'b0, 25'h0, 8'h00);
      exp_load = 1'b0;
   endtask

   task automatic status(input string tag, input logic rdy, input logic crn, input logic err);
      chk({tag, "_rom_ready"}, bus.rom_ready, rdy);
      chk({tag, "_core_reset_n"}, bus.core_reset_n, crn);
      chk({tag, "_load_error"}, bus.load_error, err);
   endtask

   initial begin
      n_checks           = 0;
      n_fail             = 0;
      exp_load           = 1'b0;
      exp_snd            = 1'b0;
      rst_n              = 1'b0;
      bus.ioctl_download = 1'b0;
      bus.ioctl_index    = 8'h00;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_addr     = '0;
      bus.ioctl_dout     = '0;

      step(1'b0, 1'b0, 8'h00, 1'b0, 25'h0, 8'h00);
      step(1'b0, 1'b0, 8'h00, 1'b0, 25'h0, 8'h00);
      idle();
      status("reset", 1'b0, 1'b0, 1'b0);

      // Stray writes with no download active must not reach the ROMs.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 25'(i * 'h1000), 8'h3C);
      idle();

      // Reset in the middle of an index-0 stream; the tail must be discarded.
      dl_start(8'h00);
      for (int unsigned i = 0; i < 'h3000; i++) step(1'b1, 1'b1, 8'h00, 1'b1, 25'(i), 8'($urandom));
      step(1'b0, 1'b1, 8'h00, 1'b1, 25'h3000, 8'hA5);
      exp_load = 1'b0;
      step(1'b1, 1'b1, 8'h00, 1'b1, 25'h3001, 8'h5A);
      status("midrst", 1'b0, 1'b0, 1'b0);
      chk("midrst_dl_wr", bus.dl_wr, 1'b0);
      for (int unsigned i = 'h3002; i < 'h3040; i++) step(1'b1, 1'b1, 8'h00, 1'b1, 25'(i), 8'($urandom));
      idle();
      idle();

      // Fresh full index-0 set.
      dl_start(8'h00);
      dl_body(8'h00, 0, 'hA000, 1'b0, 1'b0);
      idle();
      idle();
      status("main_full", 1'b0, 1'b0, 1'b0);

      // Full index-1 set, last byte coincides with the falling download.
      dl_start(8'h01);
      dl_body(8'h01, 0, 'h2000, 1'b1, 1'b0);
      idle();
      chk("snd_full_ready_early", bus.rom_ready, 1'b0);
      idle();
      status("snd_full", 1'b1, 1'b1, 1'b0);

      // Short reload of index 1: ready drops on the rise, error after check.
      dl_start(8'h01);
      status("reload_rise", 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 8'h01, 1'b1, 25'h0, 8'h11);
      chk("reload_ready_drop", bus.rom_ready, 1'b0);
      chk("reload_crn_drop", bus.core_reset_n, 1'b0);
      dl_body(8'h01, 1, 'h1FFF, 1'b0, 1'b0);
      idle();
      idle();
      status("snd_short", 1'b0, 1'b0, 1'b1);

      // Correct reload of index 1 restores ready and clears the error.
      dl_start(8'h01);
      dl_body(8'h01, 0, 'h2000, 1'b0, 1'b0);
      idle();
      idle();
      status("snd_reload", 1'b1, 1'b1, 1'b0);

      // Unknown index: ignored, core held in reset only while downloading.
      dl_start(8'hFE);
      step(1'b1, 1'b1, 8'hFE, 1'b1, 25'h0, 8'h77);
      status("idx_fe_dl", 1'b1, 1'b0, 1'b0);
      dl_body(8'hFE, 1, 16, 1'b0, 1'b0);
      idle();
      status("idx_fe_done", 1'b1, 1'b1, 1'b0);

      // Overflow byte: right total count but an address past the set size.
      dl_start(8'h01);
      dl_body(8'h01, 0, 'h2000, 1'b0, 1'b1);
      idle();
      idle();
      status("snd_ovf", 1'b0, 1'b0, 1'b1);

      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
